wf_window_map: RTL and testbench
================================

WF_WINDOW_MAP -- requirements
Module: wf_window_map

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters: none; all constants are fixed in this document.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start_x  input  10  requested window left edge (inclusive), driven by the limits FSM.
REQ-006 end_x  input  10  requested window right edge (exclusive).
REQ-007 start_y  input  10  requested window top edge (inclusive).
REQ-008 end_y  input  10  requested window bottom edge (exclusive).
REQ-009 frame_start  input  1  one-cycle pulse at the start of each frame; it is the only limit-latch point.
REQ-010 pix_valid  input  1  qualifies x/y this cycle.
REQ-011 x  input  10  current pixel column.
REQ-012 y  input  10  current pixel row.
REQ-013 out_valid  output  1  pix_valid delayed by 2 cycles.
REQ-014 in_win  output  1  pixel lies inside the active window.
REQ-015 on_border  output  1  pixel lies on the window's outermost row or column.
REQ-016 rel_x  output  10  x - active start_x when in_win, else 0.
REQ-017 rel_y  output  10  y - active start_y when in_win, else 0.
REQ-018 resize  output  1  one-cycle pulse when the active limits change.
REQ-019 limits_err  output  1  most recent latch attempt was rejected.

Function
REQ-020 Active limits (ax0, ax1, ay0, ay1) SHALL be internal registers, updated only on cycles where frame_start=1.
REQ-021 On frame_start, the inputs SHALL be accepted only if start_x<end_x and start_y<end_y; otherwise the active limits hold.
REQ-022 limits_err SHALL be registered on every frame_start: 1 on reject, 0 on accept; it holds between frame_start pulses.
REQ-023 resize SHALL pulse high for one cycle, the cycle after an accepted frame_start, iff any accepted value differs from the prior active value.
REQ-024 A pixel presented in the same cycle as an accepted frame_start SHALL be evaluated against the newly accepted limits; a rejected frame_start leaves the old limits in effect.
REQ-025 Pipeline stage 1 SHALL register pix_valid, the four compare results, and x-ax0 / y-ay0; stage 2 SHALL register all outputs. Latency is exactly 2 cycles, at one pixel per cycle with no stalls.
REQ-026 in_win SHALL be 1 iff ax0<=x<ax1 and ay0<=y<ay1, compared unsigned over 10 bits.
REQ-027 on_border SHALL be 1 iff in_win and (x==ax0 or x==ax1-1 or y==ay0 or y==ay1-1).
REQ-028 rel_x and rel_y SHALL be 10-bit differences; no wrap is possible when in_win=1; both are forced to 0 when in_win=0.
REQ-029 When a stage's pix_valid=0, that stage SHALL output in_win=0, on_border=0, rel_x=0 and rel_y=0.
REQ-030 The input limits SHALL be ignored between frame_start pulses; mid-frame changes have no effect.

Reset
REQ-031 While rst=1, all pipeline registers, out_valid, in_win, on_border, rel_x, rel_y, resize and limits_err SHALL be 0.
REQ-032 Reset SHALL load the active limits to 138/838/62/482 (x0/x1/y0/y1).
REQ-033 Reset asserted mid-frame SHALL discard all in-flight pixels; out_valid stays 0 until 2 cycles after the first post-reset pix_valid.

Verification
REQ-034 After reset, with no frame_start, drive x=138,y=62 -> 2 cycles later: in_win=1, on_border=1, rel_x=0, rel_y=0.
REQ-035 Drive frame_start with 88/888/32/512 -> resize=1 for exactly one cycle. Then x=887,y=300 -> in_win=1, on_border=1, rel_x=799, rel_y=268. Then x=888 -> in_win=0, rel_x=0.
REQ-036 Drive frame_start with start_x=500, end_x=400 -> limits_err=1, no resize pulse, active limits unchanged. A following valid frame_start -> limits_err=0.
REQ-037 Change the limit inputs mid-frame without frame_start -> outputs keep using the old limits; re-driving identical limits with frame_start -> resize stays 0.
REQ-038 Stream 1000 consecutive pixels -> out_valid matches pix_valid delayed by 2 cycles. Assert rst mid-stream -> all outputs 0 immediately, active limits = 138/838/62/482.

Source files
------------

// File: rtl/wf_window_map.sv
// Pixel window mapper: latches window limits at frame start and classifies
// each pixel as inside/border with window-relative coordinates, 2-cycle latency.
module wf_window_map (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] start_x,
  input  logic [9:0] end_x,
  input  logic [9:0] start_y,
  input  logic [9:0] end_y,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       out_valid,
  output logic       in_win,
  output logic       on_border,
  output logic [9:0] rel_x,
  output logic [9:0] rel_y,
  output logic       resize,
  output logic       limits_err
);

  localparam logic [9:0] RST_X0 = 10'd138;
  localparam logic [9:0] RST_X1 = 10'd838;
  localparam logic [9:0] RST_Y0 = 10'd62;
  localparam logic [9:0] RST_Y1 = 10'd482;

  logic [9:0] ax0, ax1, ay0, ay1;
  logic [9:0] ex0, ex1, ey0, ey1;
  logic       fits, acc, chg;

  assign fits = (start_x < end_x) && (start_y < end_y);
  assign acc  = frame_start && fits;
  assign chg  = acc && ((start_x != ax0) || (end_x != ax1) ||
                        (start_y != ay0) || (end_y != ay1));

  // An accepted latch applies to the pixel arriving in the same cycle
  always_comb begin
    ex0 = ax0;
    ex1 = ax1;
    ey0 = ay0;
    ey1 = ay1;
    if (acc) begin
      ex0 = start_x;
      ex1 = end_x;
      ey0 = start_y;
      ey1 = end_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax0        <= RST_X0;
      ax1        <= RST_X1;
      ay0        <= RST_Y0;
      ay1        <= RST_Y1;
      resize     <= 1'b0;
      limits_err <= 1'b0;
    end else begin
      resize <= chg;
      if (frame_start) limits_err <= !fits;
      if (acc) begin
        ax0 <= start_x;
        ax1 <= end_x;
        ay0 <= start_y;
        ay1 <= end_y;
      end
    end
  end

  logic       v1, gex1, ltx1, gey1, lty1, edg1;
  logic [9:0] dx1, dy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      gex1 <= 1'b0;
      ltx1 <= 1'b0;
      gey1 <= 1'b0;
      lty1 <= 1'b0;
      edg1 <= 1'b0;
      dx1  <= '0;
      dy1  <= '0;
    end else begin
      v1 <= pix_valid;
      if (pix_valid) begin
        gex1 <= x >= ex0;
        ltx1 <= x < ex1;
        gey1 <= y >= ey0;
        lty1 <= y < ey1;
        edg1 <= (x == ex0) || (x == ex1 - 10'd1) ||
                (y == ey0) || (y == ey1 - 10'd1);
        dx1  <= x - ex0;
        dy1  <= y - ey0;
      end else begin
        gex1 <= 1'b0;
        ltx1 <= 1'b0;
        gey1 <= 1'b0;
        lty1 <= 1'b0;
        edg1 <= 1'b0;
        dx1  <= '0;
        dy1  <= '0;
      end
    end
  end

  logic win1;
  assign win1 = v1 && gex1 && ltx1 && gey1 && lty1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_win    <= 1'b0;
      on_border <= 1'b0;
      rel_x     <= '0;
      rel_y     <= '0;
    end else begin
      out_valid <= v1;
      in_win    <= win1;
      on_border <= win1 && edg1;
      rel_x     <= win1 ? dx1 : 10'd0;
      rel_y     <= win1 ? dy1 : 10'd0;
    end
  end

endmodule

// File: tb/tb_wf_window_map.sv
// Self-checking bench for wf_window_map: window model plus directed checks.
module tb_wf_window_map;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] start_x, end_x, start_y, end_y;
  logic       frame_start, pix_valid;
  logic [9:0] x, y;
  logic       out_valid, in_win, on_border, resize, limits_err;
  logic [9:0] rel_x, rel_y;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  wf_window_map dut (
    .clk(clk), .rst(rst),
    .start_x(start_x), .end_x(end_x),
    .start_y(start_y), .end_y(end_y),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y),
    .out_valid(out_valid), .in_win(in_win), .on_border(on_border),
    .rel_x(rel_x), .rel_y(rel_y),
    .resize(resize), .limits_err(limits_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       w;
    logic       b;
    logic [9:0] rx;
    logic [9:0] ry;
  } res_t;

  int   m_x0, m_x1, m_y0, m_y1;
  res_t p1, p2;
  logic e_resize, e_err;

  function automatic bit lim_ok();
    return frame_start && (start_x < end_x) && (start_y < end_y);
  endfunction

  function automatic bit lim_diff();
    return (start_x != m_x0) || (end_x != m_x1) ||
           (start_y != m_y0) || (end_y != m_y1);
  endfunction

  function automatic res_t model_pix();
    res_t r;
    int x0 = lim_ok() ? int'(start_x) : m_x0;
    int x1 = lim_ok() ? int'(end_x)   : m_x1;
    int y0 = lim_ok() ? int'(start_y) : m_y0;
    int y1 = lim_ok() ? int'(end_y)   : m_y1;
    int xi = int'(x);
    int yi = int'(y);
    r = '0;
    r.v = pix_valid;
    if (pix_valid && xi >= x0 && xi < x1 && yi >= y0 && yi < y1) begin
      r.w  = 1'b1;
      r.b  = (xi == x0) || (xi == x1 - 1) || (yi == y0) || (yi == y1 - 1);
      r.rx = 10'(xi - x0);
      r.ry = 10'(yi - y0);
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x0 <= 138; m_x1 <= 838; m_y0 <= 62; m_y1 <= 482;
      p1 <= '0; p2 <= '0;
      e_resize <= 1'b0; e_err <= 1'b0;
    end else begin
      p1 <= model_pix();
      p2 <= p1;
      e_resize <= lim_ok() && lim_diff();
      if (frame_start) e_err <= !lim_ok();
      if (lim_ok()) begin
        m_x0 <= start_x; m_x1 <= end_x;
        m_y0 <= start_y; m_y1 <= end_y;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(p2.v));
      chk("in_win", 32'(in_win), 32'(p2.w));
      chk("on_border", 32'(on_border), 32'(p2.b));
      chk("rel_x", 32'(rel_x), 32'(p2.rx));
      chk("rel_y", 32'(rel_y), 32'(p2.ry));
      chk("resize", 32'(resize), 32'(e_resize));
      chk("limits_err", 32'(limits_err), 32'(e_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lim(input int a, input int b, input int c, input int d);
    start_x = 10'(a); end_x = 10'(b);
    start_y = 10'(c); end_y = 10'(d);
  endtask

  task automatic pix(input int px, input int py);
    pix_valid = 1'b1; x = 10'(px); y = 10'(py);
    step();
    pix_valid = 1'b0;
    step();
  endtask

  task automatic chk_pix(input string nm, input bit w, input bit b,
                         input int rx, input int ry);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".in_win"}, 32'(in_win), 32'(w));
    chk({nm, ".border"}, 32'(on_border), 32'(b));
    chk({nm, ".rel_x"}, 32'(rel_x), 32'(rx));
    chk({nm, ".rel_y"}, 32'(rel_y), 32'(ry));
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; pix_valid = 1'b0;
    x = '0; y = '0;
    set_lim(0, 0, 0, 0);
    step();
    chk_en = 1;
    step();
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.limits_err", 32'(limits_err), 0);
    #2 rst = 1'b0;
    step();

    pix(138, 62);
    chk_pix("reset_corner", 1, 1, 0, 0);
    pix(137, 62);
    chk_pix("reset_left_out", 0, 0, 0, 0);
    pix(837, 481);
    chk_pix("reset_far_corner", 1, 1, 699, 419);

    set_lim(88, 888, 32, 512);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("resize_pulse", 32'(resize), 1);
    step();
    chk("resize_one_cycle", 32'(resize), 0);
    pix(887, 300);
    chk_pix("right_edge", 1, 1, 799, 268);
    pix(888, 300);
    chk_pix("past_right", 0, 0, 0, 0);
    pix(400, 200);
    chk_pix("interior", 1, 0, 312, 168);

    set_lim(500, 400, 32, 512);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("reject_err", 32'(limits_err), 1);
    chk("reject_no_resize", 32'(resize), 0);
    step();
    chk("err_holds", 32'(limits_err), 1);
    pix(88, 32);
    chk_pix("reject_keeps_old", 1, 1, 0, 0);

    set_lim(88, 888, 32, 512);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("accept_clears_err", 32'(limits_err), 0);
    chk("same_limits_no_resize", 32'(resize), 0);

    set_lim(0, 10, 0, 10);
    step();
    pix(5, 5);
    chk_pix("midframe_ignored_in", 0, 0, 0, 0);
    pix(100, 100);
    chk_pix("midframe_ignored_rel", 1, 0, 12, 68);

    frame_start = 1'b1;
    pix_valid = 1'b1; x = 10'd0; y = 10'd0;
    step();
    frame_start = 1'b0; pix_valid = 1'b0;
    step();
    chk_pix("same_cycle_accept", 1, 1, 0, 0);
    pix(9, 4);
    chk_pix("small_right_border", 1, 1, 9, 4);

    set_lim(700, 600, 0, 10);
    frame_start = 1'b1;
    pix_valid = 1'b1; x = 10'd20; y = 10'd5;
    step();
    frame_start = 1'b0; pix_valid = 1'b0;
    step();
    chk_pix("same_cycle_reject", 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(0, 1023));
      frame_start = (i % 97 == 5);
      if (frame_start)
        set_lim($urandom_range(0, 500), $urandom_range(0, 1023),
                $urandom_range(0, 500), $urandom_range(0, 1023));
      step();
    end
    frame_start = 1'b0;

    pix_valid = 1'b1; x = 10'd300; y = 10'd300;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.in_win", 32'(in_win), 0);
    chk("midrst.rel_x", 32'(rel_x), 0);
    chk("midrst.resize", 32'(resize), 0);
    chk("midrst.limits_err", 32'(limits_err), 0);
    pix_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(out_valid), 0);
    pix(138, 62);
    chk_pix("post_rst_corner", 1, 1, 0, 0);
    pix(838, 100);
    chk_pix("post_rst_x1_out", 0, 0, 0, 0);

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
